multicycle_controller: RTL and testbench

//  Multi-cycle MIPS control FSM; successor to the single-cycle decoder. Sequences FETCH/DECODE/EXEC/MEM/WB over shared
//  ALU and unified memory, with a MemReady wait handshake, wait timeout, BNE/ADDI/J support and a retired-instruction

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/multicycle_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, ALU codes,
// mux-select encodings and the controller state encoding.
package mips_ctrl_pkg;

  // Supported primary opcodes (Instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation codes used outside R-type (R-type passes funct straight through)
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;

  // PC source mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B-operand mux
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // States that hold a memory request until MemReady
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // Opcodes the controller knows how to sequence
  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of a pending memory request and flags when the wait
// limit is reached. The timeout flag is registered so it shows up as a clean
// one-cycle pulse on the cycle after the give-up decision.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expire,
  output logic mem_timeout
);

  // Counter only has to reach WAIT_LIMIT-1
  localparam int CW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : '0;

  logic [CW-1:0] wait_cnt;

  // Give up only on a stalled cycle that already sits at the limit; a ready in
  // that same cycle takes priority.
  assign expire = (WAIT_LIMIT != 0) && active && !ready && (wait_cnt == LAST);

  // Count stalled cycles while the request stays pending, clear on any exit
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      mem_timeout <= expire;
      if (active && !ready && !expire) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM. Sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory. All control outputs are Moore-decoded
// from the state (plus ALUZero in BRANCH and MemReady in the wait states).
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_WIDTH = 6,
  parameter int WAIT_LIMIT  = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [31:0]            Instruction,
  input  logic                   ALUZero,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic [1:0]             PCSource,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic                   Illegal,
  output logic                   MemTimeout,
  output logic [CNT_WIDTH-1:0]   RetiredCount
);

  localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD = ALUOP_WIDTH'(ALU_ADD);
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB = ALUOP_WIDTH'(ALU_SUB);

  state_t                 state;
  state_t                 next_state;
  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic                   in_wait;
  logic                   wait_expire;
  logic                   timeout_q;
  logic                   retire;
  logic [CNT_WIDTH-1:0]   retired_q;
  logic                   unused_instr_bits;

  assign opcode            = Instruction[31:26];
  assign funct             = Instruction[5:0];
  assign unused_instr_bits = ^Instruction[25:6];

  // The timer only runs while a request is actually pending
  assign in_wait = !Rst && is_wait_state(state);

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk        (Clk),
    .rst        (Rst),
    .active     (in_wait),
    .ready      (MemReady),
    .expire     (wait_expire),
    .mem_timeout(timeout_q)
  );

  // Timeout pulse is suppressed while reset is held so every output reads 0
  assign MemTimeout   = timeout_q & ~Rst;
  assign RetiredCount = retired_q;

  // State register; reset abandons whatever instruction was in flight
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge Clk) begin
    if (Rst) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  // Next-state and control decode; everything defaults to 0 and stays 0 in reset
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    PCWrite    = 1'b0;
    PCSource   = PCSRC_ALU;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RT;
    ALUOp      = '0;
    Illegal    = 1'b0;

    if (!Rst) begin
      case (state)
        S_FETCH: begin
          // PC addresses memory while the ALU computes PC+4
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          ALUOp   = ALUOP_ADD;
          if (MemReady) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            next_state = S_DECODE;
          end else if (wait_expire) begin
            next_state = S_FETCH;
          end
        end

        S_DECODE: begin
          // Speculatively form the branch target into ALUOut
          ALUSrcB = SRCB_IMM_SH2;
          ALUOp   = ALUOP_ADD;
          case (opcode)
            OP_RTYPE:      next_state = S_EXEC_R;
            OP_LW, OP_SW:  next_state = S_MEM_ADDR;
            OP_BEQ, OP_BNE: next_state = S_BRANCH;
            OP_ADDI:       next_state = S_EXEC_I;
            OP_J:          next_state = S_JUMP;
            default: begin
              Illegal    = 1'b1;
              next_state = S_FETCH;
            end
          endcase
        end

        S_EXEC_R: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_RT;
          ALUOp      = ALUOP_WIDTH'(funct);
          next_state = S_WB_R;
        end

        S_WB_R: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end

        S_EXEC_I: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          ALUOp      = ALUOP_ADD;
          next_state = S_WB_I;
        end

        S_WB_I: begin
          RegWrite   = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end

        S_MEM_ADDR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          ALUOp      = ALUOP_ADD;
          next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end

        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (MemReady) begin
            next_state = S_WB_MEM;
          end else if (wait_expire) begin
            next_state = S_FETCH;
          end
        end

        S_WB_MEM: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end

        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (MemReady) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end else if (wait_expire) begin
            next_state = S_FETCH;
          end
        end

        S_BRANCH: begin
          // rs - rt; zero flag decides, polarity picked by BEQ vs BNE
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_RT;
          ALUOp      = ALUOP_SUB;
          PCSource   = PCSRC_ALUOUT;
          PCWrite    = (opcode == OP_BNE) ? !ALUZero : ALUZero;
          retire     = 1'b1;
          next_state = S_FETCH;
        end

        S_JUMP: begin
          PCSource   = PCSRC_JUMP;
          PCWrite    = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end

        default: begin
          next_state = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into its expected per-cycle control words from the instruction class and the
// stall pattern the bench itself applies; one compare process checks every cycle.
module tb_multicycle_controller;

  localparam int LIMIT = 4;
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;

  localparam int L_ALUOP = 0;
  localparam int L_CNT   = 1;
  localparam int L_PCW   = 2;
  localparam int L_MT    = 3;
  localparam int L_ILL   = 4;
  localparam int L_M2R   = 5;
  localparam int L_RDST  = 6;

  typedef struct packed {
    logic       pcwrite;
    logic [1:0] pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [5:0] aluop;
    logic       illegal;
    logic       memtimeout;
  } ctl_t;

  logic        Clk = 1'b1;
  logic        Rst;
  logic [31:0] Instruction;
  logic        ALUZero;
  logic        MemReady;
  logic        PCWrite;
  logic [1:0]  PCSource;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [5:0]  ALUOp;
  logic        Illegal;
  logic        MemTimeout;
  logic [31:0] RetiredCount;

  multicycle_controller #(
    .ALUOP_WIDTH(6),
    .WAIT_LIMIT (LIMIT),
    .CNT_WIDTH  (32)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Instruction (Instruction),
    .ALUZero     (ALUZero),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCSource    (PCSource),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .Illegal     (Illegal),
    .MemTimeout  (MemTimeout),
    .RetiredCount(RetiredCount)
  );

  always #5 Clk = ~Clk;

  ctl_t        act;
  ctl_t        exp_c;
  logic [31:0] exp_cnt;
  logic [31:0] model_cnt = '0;
  bit          exp_vld = 1'b0;
  bit          chk_cnt = 1'b0;
  bit          pend_to = 1'b0;
  int          cyc_n = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  int          lit_at  [16];
  int          lit_sel [16];
  logic [31:0] lit_val [16];
  int          nlit = 0;

  assign act = {PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst,
                MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, Illegal, MemTimeout};

  // Compare DUT outputs against the model mid-cycle, plus pinned literals
  always @(negedge Clk) begin : cmp
    logic [31:0] a;
    string       nm;
    if (exp_vld) begin
      n_chk++;
      if (act === exp_c) n_pass++;
      else $display("FAIL ctrl cycle=%0d instr=%08h got=%06h want=%06h", cyc_n, Instruction, act, exp_c);
      if (chk_cnt) begin
        n_chk++;
        if (RetiredCount === exp_cnt) n_pass++;
        else $display("FAIL retired cycle=%0d got=%0d want=%0d", cyc_n, RetiredCount, exp_cnt);
      end
      for (int k = 0; k < nlit; k++) begin
        if (lit_at[k] == cyc_n) begin
          case (lit_sel[k])
            L_ALUOP: begin a = 32'(ALUOp);      nm = "lit_aluop";      end
            L_CNT:   begin a = RetiredCount;    nm = "lit_retired";    end
            L_PCW:   begin a = 32'(PCWrite);    nm = "lit_pcwrite";    end
            L_MT:    begin a = 32'(MemTimeout); nm = "lit_memtimeout"; end
            L_ILL:   begin a = 32'(Illegal);    nm = "lit_illegal";    end
            L_M2R:   begin a = 32'(MemtoReg);   nm = "lit_memtoreg";   end
            default: begin a = 32'(RegDst);     nm = "lit_regdst";     end
          endcase
          n_chk++;
          if (a === lit_val[k]) n_pass++;
          else $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc_n, a, lit_val[k]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02};
  endfunction

  function automatic int stall_len();
    return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 5));
  endfunction

  function automatic logic [31:0] gen(input int kind);
    logic [31:0] r;
    logic [5:0]  op;
    r = $urandom;
    case (kind)
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2b;
      3: op = 6'h04;
      4: op = 6'h05;
      5: op = 6'h08;
      6: op = 6'h02;
      default: begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end
    endcase
    r[31:26] = op;
    return r;
  endfunction

  task automatic add_lit(input int at, input int sel, input logic [31:0] val);
    lit_at[nlit]  = at;
    lit_sel[nlit] = sel;
    lit_val[nlit] = val;
    nlit++;
  endtask

  // One clock cycle: drive inputs, publish the expected control word
  task automatic step(input ctl_t e, input logic rdy, input logic zero, input logic rst);
    cyc_n++;
    Rst      = rst;
    MemReady = rdy;
    ALUZero  = zero;
    e.memtimeout = pend_to && !rst;
    pend_to  = 1'b0;
    exp_c    = e;
    exp_cnt  = model_cnt;
    exp_vld  = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      step('0, rb(), rb(), 1'b1);
      model_cnt = '0;
      pend_to   = 1'b0;
    end
  endtask

  // Request held for `stalls` cycles then accepted, unless the limit is reached
  task automatic wait_phase(input ctl_t hold, input ctl_t fin, input int stalls, output bit tout);
    tout = 1'b0;
    for (int i = 0; i < stalls; i++) begin
      step(hold, 1'b0, rb(), 1'b0);
      if (i == LIMIT - 1) begin
        pend_to = 1'b1;
        tout    = 1'b1;
        return;
      end
    end
    step(fin, 1'b1, rb(), 1'b0);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fst, input int mst, input logic zero);
    ctl_t       c;
    ctl_t       f;
    bit         to;
    logic [5:0] op;
    op = ins[31:26];
    Instruction = ins;
    c = '0; c.memread = 1'b1; c.alusrcb = 2'b01; c.aluop = ADD;
    f = c;  f.irwrite = 1'b1; f.pcwrite = 1'b1;
    wait_phase(c, f, fst, to);
    if (to) return;
    c = '0; c.alusrcb = 2'b11; c.aluop = ADD; c.illegal = !legal(op);
    step(c, rb(), rb(), 1'b0);
    if (!legal(op)) return;
    c = '0;
    case (op)
      6'h00: begin
        c.alusrca = 1'b1; c.aluop = ins[5:0];
        step(c, rb(), rb(), 1'b0);
        c = '0; c.regdst = 1'b1; c.regwrite = 1'b1;
        step(c, rb(), rb(), 1'b0);
        model_cnt++;
      end
      6'h08: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = ADD;
        step(c, rb(), rb(), 1'b0);
        c = '0; c.regwrite = 1'b1;
        step(c, rb(), rb(), 1'b0);
        model_cnt++;
      end
      6'h23, 6'h2b: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = ADD;
        step(c, rb(), rb(), 1'b0);
        c = '0; c.iord = 1'b1;
        if (op == 6'h23) c.memread = 1'b1;
        else             c.memwrite = 1'b1;
        wait_phase(c, c, mst, to);
        if (!to) begin
          if (op == 6'h23) begin
            c = '0; c.memtoreg = 1'b1; c.regwrite = 1'b1;
            step(c, rb(), rb(), 1'b0);
          end
          model_cnt++;
        end
      end
      6'h04, 6'h05: begin
        c.alusrca = 1'b1; c.aluop = SUB; c.pcsource = 2'b01;
        c.pcwrite = (op == 6'h04) ? zero : !zero;
        step(c, rb(), zero, 1'b0);
        model_cnt++;
      end
      default: begin
        c.pcsource = 2'b10; c.pcwrite = 1'b1;
        step(c, rb(), rb(), 1'b0);
        model_cnt++;
      end
    endcase
  endtask

  // Reset mid-instruction: some fetch stalls, optionally through decode, then Rst
  task automatic abort_seq(input logic [31:0] ins, input int st, input bit past_dec);
    ctl_t c;
    Instruction = ins;
    c = '0; c.memread = 1'b1; c.alusrcb = 2'b01; c.aluop = ADD;
    for (int i = 0; i < st; i++) step(c, 1'b0, rb(), 1'b0);
    if (past_dec) begin
      c.irwrite = 1'b1; c.pcwrite = 1'b1;
      step(c, 1'b1, rb(), 1'b0);
      c = '0; c.alusrcb = 2'b11; c.aluop = ADD; c.illegal = !legal(ins[31:26]);
      step(c, rb(), rb(), 1'b0);
    end
    do_reset(1 + int'($urandom_range(0, 1)));
  endtask

  initial begin
    int s;
    Rst = 1'b1; MemReady = 1'b1; ALUZero = 1'b0; Instruction = '0;

    step('0, 1'b1, 1'b0, 1'b1);
    chk_cnt   = 1'b1;
    model_cnt = '0;
    step('0, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);

    s = cyc_n;
    add_lit(s + 1, L_CNT, 32'd0);
    add_lit(s + 3, L_ALUOP, 32'h20);
    add_lit(s + 4, L_RDST, 32'd1);
    add_lit(s + 5, L_CNT, 32'd1);
    run_instr(32'h012A4020, 0, 0, 1'b0);

    s = cyc_n;
    add_lit(s + 8, L_M2R, 32'd1);
    add_lit(s + 9, L_CNT, 32'd2);
    run_instr(32'h8D090004, 0, 3, 1'b0);

    s = cyc_n;
    add_lit(s + 3, L_PCW, 32'd1);
    run_instr(32'h11090003, 0, 0, 1'b1);

    s = cyc_n;
    add_lit(s + 3, L_PCW, 32'd0);
    add_lit(s + 4, L_CNT, 32'd4);
    run_instr(32'h15090003, 0, 0, 1'b1);

    run_instr(32'hAD090004, 0, 10, 1'b0);

    s = cyc_n;
    add_lit(s + 1, L_MT, 32'd1);
    add_lit(s + 1, L_CNT, 32'd4);
    add_lit(s + 2, L_ILL, 32'd1);
    add_lit(s + 3, L_CNT, 32'd4);
    run_instr(32'hFC000000, 0, 0, 1'b0);

    abort_seq(32'h012A4020, 2, 1'b1);
    add_lit(cyc_n + 1, L_CNT, 32'd0);
    run_instr(32'h08000010, 0, 0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        abort_seq(gen(int'($urandom_range(0, 7))), int'($urandom_range(0, LIMIT - 1)), bit'(rb()));
      end else begin
        run_instr(gen(int'($urandom_range(0, 7))), stall_len(), stall_len(), rb());
      end
    end
    run_instr(32'h012A4020, 0, 0, 1'b0);

    exp_vld = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
